// File: rtl/if_id_skid_stage_pkg.sv
// Shared types and constants for the IF/ID skid stage.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch-to-decode handshake bundle carried through the IF/ID stage.
interface if_id_skid_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_ir;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_ir;

    modport master (
        output in_valid, in_pc, in_ir,
        input  in_ready, out_valid, out_pc, out_ir
    );

    modport slave (
        input  in_valid, in_pc, in_ir,
        output in_ready, out_valid, out_pc, out_ir
    );
endinterface

// File: rtl/if_id_skid_stage_sat_counter.sv
// Saturating event counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready toward fetch, a one-entry skid
// buffer behind the main entry, and saturating stall/flush counters.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEF),
    parameter logic [XLEN-1:0] PC_RESET  = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               stall,
    input  logic               flush,
    if_id_skid_stage_if.slave  bus,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic [ILEN-1:0] main_ir_q, main_ir_d;
    logic [XLEN-1:0] s_pc_q, s_pc_d;
    logic [ILEN-1:0] s_ir_q, s_ir_d;
    logic            in_ready_q, in_ready_d;

    logic out_valid;
    logic s_valid;
    logic fire_in;
    logic cons;
    logic stall_inc;
    logic flush_inc;

    assign out_valid = (state_q != EMPTY);
    assign s_valid   = (state_q == SKID);
    assign fire_in   = en & bus.in_valid & in_ready_q;
    assign cons      = en & ~stall;

    always_comb begin
        state_d   = state_q;
        main_pc_d = main_pc_q;
        main_ir_d = main_ir_q;
        s_pc_d    = s_pc_q;
        s_ir_d    = s_ir_q;

        if (flush) begin
            state_d   = EMPTY;
            main_pc_d = PC_RESET;
            main_ir_d = NOP_INSTR;
            s_pc_d    = PC_RESET;
            s_ir_d    = NOP_INSTR;
        end else if (en) begin
            unique case (state_q)
                EMPTY: begin
                    if (fire_in) begin
                        state_d   = FULL;
                        main_pc_d = bus.in_pc;
                        main_ir_d = bus.in_ir;
                    end
                end
                FULL: begin
                    if (cons && fire_in) begin
                        main_pc_d = bus.in_pc;
                        main_ir_d = bus.in_ir;
                    end else if (cons) begin
                        state_d   = EMPTY;
                        main_pc_d = PC_RESET;
                        main_ir_d = NOP_INSTR;
                    end else if (fire_in) begin
                        state_d = SKID;
                        s_pc_d  = bus.in_pc;
                        s_ir_d  = bus.in_ir;
                    end
                end
                SKID: begin
                    // in_ready is low here, so no new input can arrive
                    if (cons) begin
                        state_d   = FULL;
                        main_pc_d = s_pc_q;
                        main_ir_d = s_ir_q;
                        s_pc_d    = PC_RESET;
                        s_ir_d    = NOP_INSTR;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_pc_q  <= PC_RESET;
            main_ir_q  <= NOP_INSTR;
            s_pc_q     <= PC_RESET;
            s_ir_q     <= NOP_INSTR;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_pc_q  <= main_pc_d;
            main_ir_q  <= main_ir_d;
            s_pc_q     <= s_pc_d;
            s_ir_q     <= s_ir_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign stall_inc = en & stall & out_valid;
    assign flush_inc = flush & (out_valid | s_valid | (bus.in_valid & in_ready_q));

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = main_pc_q;
    assign bus.out_ir    = main_ir_q;
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed and randomized bench for if_id_skid_stage against a queue model.
module tb_if_id_skid_stage;
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic stall;
    logic flush;

    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Model: in-order list of instructions held by the stage (at most two)
    logic [63:0] mq[$];
    logic        m_ready;
    int unsigned m_scnt;
    int unsigned m_fcnt;

    always #5 clk = ~clk;

    if_id_skid_stage_if #(.XLEN(32), .ILEN(32)) bus ();
    if_id_skid_stage_if #(.XLEN(32), .ILEN(32)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_pc    = bus.in_pc;
    assign bus2.in_ir    = bus.in_ir;

    if_id_skid_stage #(.XLEN(32), .ILEN(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .stall     (stall),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    if_id_skid_stage #(.XLEN(32), .ILEN(32), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .stall     (stall),
        .flush     (flush),
        .bus       (bus2),
        .stall_cnt (stall_cnt2),
        .flush_cnt (flush_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_step();
        logic accept;
        if (!rst) begin
            mq.delete();
            m_ready = 1'b1;
            m_scnt  = 0;
            m_fcnt  = 0;
        end else begin
            accept = bus.in_valid && m_ready;
            if (en && stall && mq.size() > 0) m_scnt++;
            if (flush) begin
                if (mq.size() > 0 || accept) m_fcnt++;
                mq.delete();
                m_ready = 1'b1;
            end else if (en) begin
                if (!stall && mq.size() > 0) void'(mq.pop_front());
                if (accept) mq.push_back({bus.in_pc, bus.in_ir});
                m_ready = (mq.size() < 2);
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] e_pc, e_ir;
        logic        e_v;
        e_v  = (mq.size() > 0);
        e_pc = e_v ? mq[0][63:32] : 32'h0;
        e_ir = e_v ? mq[0][31:0]  : 32'h0000_0013;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, e_v});
        chk("out_pc", bus.out_pc, e_pc);
        chk("out_ir", bus.out_ir, e_ir);
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready});
        chk("stall_cnt", {16'b0, stall_cnt}, sat(m_scnt, 32'hFFFF));
        chk("flush_cnt", {16'b0, flush_cnt}, sat(m_fcnt, 32'hFFFF));
        chk("sat_out_pc", bus2.out_pc, e_pc);
        chk("sat_stall_cnt", {30'b0, stall_cnt2}, sat(m_scnt, 3));
        chk("sat_flush_cnt", {30'b0, flush_cnt2}, sat(m_fcnt, 3));
    endtask

    task automatic cycle(input logic en_i, input logic st_i, input logic fl_i,
                         input logic v_i, input logic [31:0] pc_i, input logic [31:0] ir_i);
        en           = en_i;
        stall        = st_i;
        flush        = fl_i;
        bus.in_valid = v_i;
        bus.in_pc    = pc_i;
        bus.in_ir    = ir_i;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc    = '0;
        bus.in_ir    = '0;
        #2;

        // Reset state
        do_reset();
        chk("rst_out_ir", bus.out_ir, 32'h0000_0013);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

        // First instruction, one-cycle latency
        cycle(1, 0, 0, 1, 32'h100, 32'h0050_0093);
        chk("first_pc", bus.out_pc, 32'h100);
        chk("first_ir", bus.out_ir, 32'h0050_0093);

        // Streaming without stall
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 1, 32'(i * 4), 32'h1000 + 32'(i));
            chk("stream_pc", bus.out_pc, 32'(i * 4));
        end
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
        chk("stream_drain", {31'b0, bus.out_valid}, 32'h0);
        chk("stream_stall_cnt", {16'b0, stall_cnt}, 32'h0);

        // Stall with skid capture and backpressure
        do_reset();
        cycle(1, 0, 0, 1, 32'h4, 32'hA4);
        cycle(1, 1, 0, 1, 32'h8, 32'hA8);
        chk("skid_in_ready", {31'b0, bus.in_ready}, 32'h0);
        cycle(1, 1, 0, 1, 32'hC, 32'hAC);
        cycle(1, 1, 0, 1, 32'hC, 32'hAC);
        chk("skid_hold_pc", bus.out_pc, 32'h4);
        chk("skid_stall_cnt", {16'b0, stall_cnt}, 32'h3);
        cycle(1, 0, 0, 1, 32'hC, 32'hAC);
        chk("release_pc8", bus.out_pc, 32'h8);
        cycle(1, 0, 0, 1, 32'hC, 32'hAC);
        chk("release_pcC", bus.out_pc, 32'hC);
        cycle(1, 0, 0, 0, 32'h0, 32'h0);

        // Flush with stall while in SKID
        do_reset();
        cycle(1, 0, 0, 1, 32'h20, 32'hB0);
        cycle(1, 1, 0, 1, 32'h24, 32'hB4);
        cycle(1, 1, 1, 1, 32'h28, 32'hB8);
        chk("flush_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("flush_ir", bus.out_ir, 32'h0000_0013);
        chk("flush_cnt1", {16'b0, flush_cnt}, 32'h1);

        // en=0 freezes the stage
        cycle(1, 0, 0, 1, 32'h40, 32'hC0);
        cycle(0, 0, 0, 1, 32'h44, 32'hC4);
        cycle(0, 0, 0, 1, 32'h44, 32'hC4);
        chk("en0_pc", bus.out_pc, 32'h40);
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 1, 0, 32'h0, 32'h0);
        chk("idle_flush_cnt", {16'b0, flush_cnt}, 32'h1);

        // Counter saturation on the narrow instance
        do_reset();
        cycle(1, 0, 0, 1, 32'h50, 32'hD0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 32'h0, 32'h0);
        chk("sat_stall3", {30'b0, stall_cnt2}, 32'h3);
        chk("wide_stall6", {16'b0, stall_cnt}, 32'h6);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic e, s, f, v;
            rst = ($urandom_range(0, 99) != 0);
            e   = ($urandom_range(0, 7) != 0);
            s   = ($urandom_range(0, 2) == 0);
            f   = e && ($urandom_range(0, 11) == 0);
            v   = ($urandom_range(0, 3) != 0);
            cycle(e, s, f, v, {$urandom_range(0, 16383), 2'b00}, $urandom);
        end
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage for the pipelined RISC-V core. It holds the fetched instruction and its PC, and inserts a NOP bubble on flush. It also adds a valid/ready handshake toward fetch, a one-entry skid buffer so fetch is never lost under a decode stall, and saturating stall/flush event counters. It sits between the instruction-memory output and the ID stage and replaces the fixed 32-bit latch.

## Interface
- XLEN, 32, PC width
- ILEN, 32, instruction width
- NOP_INSTR, 32'h0000_0013, value driven on out_ir when empty or flushed (addi x0,x0,0)
- PC_RESET, 0, value driven on out_pc when empty or flushed
- CNT_W, 16, width of each event counter

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- en  in  1  global stage enable; 0 = freeze every register and counter
- stall  in  1  ID-side data hazard; current instruction is not consumed
- flush  in  1  control hazard; discard all held and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept (registered)
- in_pc  in  XLEN  PC of the incoming instruction
- in_ir  in  ILEN  incoming instruction word
- out_valid  out  1  out_pc/out_ir hold a real instruction
- out_pc  out  XLEN  PC to ID
- out_ir  out  ILEN  instruction to ID
- stall_cnt  out  CNT_W  cycles a valid instruction was held by stall
- flush_cnt  out  CNT_W  flushes that discarded at least one valid instruction

## Operation
- Signal definitions:
  - fire_in = en & in_valid & in_ready
  - cons = en & ~stall (ID takes main this cycle; meaningful only when out_valid)
- Storage: main entry (out_valid/out_pc/out_ir) plus skid entry (s_valid/s_pc/s_ir).
- States: EMPTY (main invalid), FULL (main valid, skid invalid), SKID (both valid). in_ready = (next state != SKID), registered.
- Priority: rst > flush > en=0 hold > normal transitions.
- EMPTY: fire_in → FULL, load main; otherwise stay.
- FULL:
  - cons & fire_in → FULL, main ← input
  - cons & ~fire_in → EMPTY
  - ~cons & fire_in → SKID, skid ← input
  - otherwise hold
- SKID (in_ready=0): cons → FULL, main ← skid, skid cleared; otherwise hold.
- Whenever main becomes empty: out_ir ← NOP_INSTR, out_pc ← PC_RESET.
- Flush (regardless of en):
  - next state EMPTY; main and skid cleared to NOP/PC_RESET
  - same-cycle input is discarded; in_ready ← 1
- Flush with stall in the same cycle: flush wins.
- stall_cnt: +1 each cycle with en & stall & out_valid; saturates at 2^CNT_W−1.
- flush_cnt: +1 on flush when out_valid | s_valid | (in_valid & in_ready); saturates.
- Counters are reset only by rst.

## Timing
- Reset (rst=0 at a clk edge): state EMPTY, out_valid=0, out_ir=NOP_INSTR, out_pc=PC_RESET, s_valid=0, in_ready=1, both counters 0.
- Latency: accepted instruction appears on out_* the next cycle (1 cycle); through the skid, 1 cycle after the stall releases.
- Throughput: one instruction per cycle with no stall.
- Backpressure: in_ready drops the cycle after a stall captures into the skid. No input is ever dropped except by flush.
- Reset asserted mid-operation: held and skid instructions are discarded; counters clear.
- en=0: all state holds; in_ready holds its value but nothing is accepted.

## Structure
- Package if_id_pkg:
  - state enum {EMPTY, FULL, SKID}
  - default NOP_INSTR constant
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated twice for the event counters.
- Main and skid entries live in the top module.

## Test plan
- Reset, then in_valid=1 with pc=0x100, ir=0x00500093 → next cycle out_valid=1, out_pc=0x100, out_ir=0x00500093; in_ready=1.
- Streaming pcs 0x0,0x4,0x8,0xC with stall=0 → each appears exactly one cycle later, no gaps; counters stay 0.
- Hold main=0x4, then stall for 3 cycles while fetch offers 0x8 then 0xC:
  - 0x8 goes to skid; in_ready=0 from the next cycle; 0xC is held off
  - on release, out shows 0x4 → 0x8 → 0xC in order
  - stall_cnt=3
- State SKID, then flush=1 with stall=1 → next cycle out_valid=0, out_ir=0x00000013, out_pc=0, in_ready=1, flush_cnt=1.
- en=0 for 2 cycles with in_valid=1 → no state change, no acceptance; flush while empty with in_valid=0 leaves flush_cnt unchanged.
- Force CNT_W=2 and stall 6 cycles with valid main → stall_cnt saturates at 3.
